// File: rtl/mips_fetch_sequencer.sv
// ---------------------------------------------------------------------------
// mips_fetch_sequencer
//   Multi-cycle MIPS instruction sequencer.  Each instruction is fetched
//   (FETCH), then executed in one or two cycles (EXEC1, optional EXEC2).
//   Branches and jumps are captured in EXEC1 and applied after the
//   following delay-slot instruction commits.  A commit of PC value zero
//   parks the sequencer in HALT until reset.
//
// Ports
//   clk          rising-edge clock
//   reset        synchronous active-high reset
//   waitrequest  memory busy, stalls FETCH and EXEC1
//   readdata     instruction word from memory during FETCH
//   Extra        decoder: instruction needs an EXEC2 cycle
//   is_branch    decoder: jump or taken branch (sampled in EXEC1)
//   PCControl    target select: 00 relative, 01 J-index, 1x register
//   rs_data      register-file rs value (JR/JALR target)
//   state        00 FETCH, 01 EXEC1, 10 EXEC2, 11 HALT
//   instr        instruction register
//   pc           address of the current instruction
//   link_addr    pc + 8, return address for linking instructions
//   active       high while not in HALT
// ---------------------------------------------------------------------------
module mips_fetch_sequencer #(
    parameter logic [31:0] RESET_VECTOR = 32'hBFC0_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        waitrequest,
    input  logic [31:0] readdata,
    input  logic        Extra,
    input  logic        is_branch,
    input  logic [1:0]  PCControl,
    input  logic [31:0] rs_data,
    output logic [1:0]  state,
    output logic [31:0] instr,
    output logic [31:0] pc,
    output logic [31:0] link_addr,
    output logic        active
);

    typedef enum logic [1:0] {
        ST_FETCH = 2'b00,
        ST_EXEC1 = 2'b01,
        ST_EXEC2 = 2'b10,
        ST_HALT  = 2'b11
    } state_t;

    state_t      r_state;
    logic [31:0] r_pc;
    logic [31:0] r_instr;
    logic        r_pending;
    logic [31:0] r_target;

    state_t      w_state_nxt;
    logic [31:0] w_pc_nxt;
    logic [31:0] w_instr_nxt;
    logic        w_pending_nxt;
    logic [31:0] w_target_nxt;

    logic [31:0] w_pc_plus4;
    logic [31:0] w_branch_target;
    logic [31:0] w_commit_pc;
    logic        w_commit_halt;
    logic        w_capture;

    assign w_pc_plus4    = r_pc + 32'd4;
    // A pending redirect wins over sequential advance at commit time.
    assign w_commit_pc   = r_pending ? r_target : w_pc_plus4;
    assign w_commit_halt = (w_commit_pc == 32'h0000_0000);
    // Only the first branch is captured; a branch sitting in the delay slot
    // sees r_pending=1 and is dropped.
    assign w_capture     = (r_state == ST_EXEC1) && !waitrequest && is_branch && !r_pending;

    // Branch/jump target selection from the current instruction.
    always_comb begin
        w_branch_target = w_pc_plus4;
        case (PCControl)
            2'b00:   w_branch_target = w_pc_plus4 + {{14{r_instr[15]}}, r_instr[15:0], 2'b00};
            2'b01:   w_branch_target = {w_pc_plus4[31:28], r_instr[25:0], 2'b00};
            default: w_branch_target = rs_data;
        endcase
    end

    // Next-state and next-register computation for the sequencer.
    always_comb begin
        w_state_nxt   = r_state;
        w_pc_nxt      = r_pc;
        w_instr_nxt   = r_instr;
        w_pending_nxt = r_pending;
        w_target_nxt  = r_target;
        case (r_state)
            ST_FETCH: begin
                if (!waitrequest) begin
                    w_instr_nxt = readdata;
                    w_state_nxt = ST_EXEC1;
                end else begin
                    w_state_nxt = ST_FETCH;
                end
            end
            ST_EXEC1: begin
                if (!waitrequest) begin
                    if (Extra) begin
                        w_state_nxt = ST_EXEC2;
                    end else begin
                        w_pc_nxt      = w_commit_pc;
                        w_pending_nxt = 1'b0;
                        w_state_nxt   = w_commit_halt ? ST_HALT : ST_FETCH;
                    end
                end else begin
                    w_state_nxt = ST_EXEC1;
                end
                // Capture only happens with r_pending=0, so it never races
                // a commit that consumes a pending target.
                if (w_capture) begin
                    w_pending_nxt = 1'b1;
                    w_target_nxt  = w_branch_target;
                end else begin
                    w_target_nxt  = r_target;
                end
            end
            ST_EXEC2: begin
                w_pc_nxt      = w_commit_pc;
                w_pending_nxt = 1'b0;
                w_state_nxt   = w_commit_halt ? ST_HALT : ST_FETCH;
            end
            ST_HALT: begin
                w_state_nxt = ST_HALT;
            end
            default: begin
                w_state_nxt = ST_FETCH;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= ST_FETCH;
            r_pc      <= RESET_VECTOR;
            r_instr   <= 32'h0000_0000;
            r_pending <= 1'b0;
            r_target  <= 32'h0000_0000;
        end else begin
            r_state   <= w_state_nxt;
            r_pc      <= w_pc_nxt;
            r_instr   <= w_instr_nxt;
            r_pending <= w_pending_nxt;
            r_target  <= w_target_nxt;
        end
    end

    assign state     = r_state;
    assign instr     = r_instr;
    assign pc        = r_pc;
    assign link_addr = r_pc + 32'd8;
    assign active    = (r_state != ST_HALT);

endmodule

// File: tb/tb_mips_fetch_sequencer.sv
module tb_mips_fetch_sequencer;

    localparam logic [31:0] RV = 32'hBFC0_0000;

    logic        clk;
    logic        reset;
    logic        waitrequest;
    logic [31:0] readdata;
    logic        Extra;
    logic        is_branch;
    logic [1:0]  PCControl;
    logic [31:0] rs_data;
    logic [1:0]  state;
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] link_addr;
    logic        active;

    int n_checks = 0;
    int n_fail   = 0;

    mips_fetch_sequencer #(.RESET_VECTOR(RV)) dut (
        .clk(clk), .reset(reset), .waitrequest(waitrequest), .readdata(readdata),
        .Extra(Extra), .is_branch(is_branch), .PCControl(PCControl), .rs_data(rs_data),
        .state(state), .instr(instr), .pc(pc), .link_addr(link_addr), .active(active)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: phase number, program counter, IR, redirect slot.
    int          m_phase;
    logic [31:0] m_pc;
    logic [31:0] m_ir;
    logic        m_have_redirect;
    logic [31:0] m_redirect;
    logic        m_valid = 1'b0;

    function automatic logic [31:0] f_target(input logic [31:0] p, input logic [31:0] ins,
                                             input logic [1:0] sel, input logic [31:0] rs);
        int off;
        off = int'($signed(ins[15:0]));
        if (sel == 2'b00) return p + 32'd4 + 32'(off * 4);
        else if (sel == 2'b01) return ((p + 32'd4) & 32'hF000_0000) | ((ins & 32'h03FF_FFFF) << 2);
        else return rs;
    endfunction

    task automatic retire();
        logic [31:0] nxt;
        nxt = m_have_redirect ? m_redirect : m_pc + 32'd4;
        m_have_redirect = 1'b0;
        m_pc = nxt;
        m_phase = (nxt == 32'd0) ? 3 : 0;
    endtask

    task automatic model_step();
        logic        take;
        logic [31:0] tgt;
        if (reset) begin
            m_phase = 0; m_pc = RV; m_ir = 32'd0;
            m_have_redirect = 1'b0; m_redirect = 32'd0; m_valid = 1'b1;
        end else if (m_valid) begin
            if (m_phase == 0) begin
                if (!waitrequest) begin m_ir = readdata; m_phase = 1; end
            end else if (m_phase == 1) begin
                if (!waitrequest) begin
                    take = is_branch && !m_have_redirect;
                    tgt  = f_target(m_pc, m_ir, PCControl, rs_data);
                    if (Extra) m_phase = 2;
                    else retire();
                    if (take) begin m_have_redirect = 1'b1; m_redirect = tgt; end
                end
            end else if (m_phase == 2) begin
                retire();
            end
        end
    endtask

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle model update and comparison, #1 after the active edge.
    initial begin
        forever begin
            @(posedge clk);
            model_step();
            #1;
            if (m_valid) begin
                cmp("model_state", {30'd0, state}, 32'(m_phase));
                cmp("model_pc", pc, m_pc);
                cmp("model_instr", instr, m_ir);
                cmp("model_link", link_addr, m_pc + 32'd8);
                cmp("model_active", {31'd0, active}, {31'd0, (m_phase != 3)});
            end
        end
    end

    // Apply one cycle of inputs at the negedge; return at the next negedge.
    task automatic step(input logic rst, input logic wr, input logic [31:0] rd, input logic ex,
                        input logic br, input logic [1:0] pcc, input logic [31:0] rs);
        reset = rst; waitrequest = wr; readdata = rd; Extra = ex;
        is_branch = br; PCControl = pcc; rs_data = rs;
        @(negedge clk);
    endtask

    task automatic do_reset();
        step(1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 2'b00, 32'd0);
    endtask

    // Fetch word w, then execute it with the given decoder flags.
    task automatic run_instr(input logic [31:0] w, input logic br, input logic [1:0] pcc,
                             input logic [31:0] rs);
        step(1'b0, 1'b0, w, 1'b0, 1'b0, 2'b00, 32'd0);
        step(1'b0, 1'b0, 32'h0, 1'b0, br, pcc, rs);
    endtask

    initial begin
        reset = 1'b1; waitrequest = 1'b0; readdata = 32'd0; Extra = 1'b0;
        is_branch = 1'b0; PCControl = 2'b00; rs_data = 32'd0;
        @(negedge clk);

        // Reset state
        do_reset();
        cmp("rst_state", {30'd0, state}, 32'd0);
        cmp("rst_pc", pc, 32'hBFC0_0000);
        cmp("rst_instr", instr, 32'h0);
        cmp("rst_active", {31'd0, active}, 32'd1);

        // Plain two-cycle instruction
        step(1'b0, 1'b0, 32'h2401_0005, 1'b0, 1'b0, 2'b00, 32'd0);
        cmp("v1_state1", {30'd0, state}, 32'd1);
        cmp("v1_instr", instr, 32'h2401_0005);
        step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 2'b00, 32'd0);
        cmp("v1_state2", {30'd0, state}, 32'd0);
        cmp("v1_pc", pc, 32'hBFC0_0004);
        cmp("v1_link", link_addr, 32'hBFC0_000C);

        // Fetch stall for 3 cycles
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0, 2'b00, 32'd0);
            cmp("v2_stall_state", {30'd0, state}, 32'd0);
            cmp("v2_stall_instr", instr, 32'h2401_0005);
        end
        step(1'b0, 1'b0, 32'h0000_0001, 1'b0, 1'b0, 2'b00, 32'd0);
        cmp("v2_load", instr, 32'h0000_0001);

        // Extra cycle; waitrequest ignored in EXEC2
        step(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 2'b00, 32'd0);
        cmp("v3_exec2_state", {30'd0, state}, 32'd2);
        cmp("v3_exec2_pc", pc, 32'hBFC0_0004);
        step(1'b0, 1'b1, 32'h0, 1'b0, 1'b0, 2'b00, 32'd0);
        cmp("v3_done_state", {30'd0, state}, 32'd0);
        cmp("v3_done_pc", pc, 32'hBFC0_0008);

        // EXEC1 stall holds everything
        step(1'b0, 1'b0, 32'h1234_5678, 1'b0, 1'b0, 2'b00, 32'd0);
        step(1'b0, 1'b1, 32'h0, 1'b0, 1'b1, 2'b00, 32'd0);
        step(1'b0, 1'b1, 32'h0, 1'b0, 1'b1, 2'b00, 32'd0);
        cmp("e1_stall_state", {30'd0, state}, 32'd1);
        cmp("e1_stall_pc", pc, 32'hBFC0_0008);
        step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 2'b00, 32'd0);
        cmp("e1_release_pc", pc, 32'hBFC0_000C);

        // Relative branch back to itself, branch in delay slot ignored
        do_reset();
        run_instr(32'h1000_FFFF, 1'b1, 2'b00, 32'd0);
        cmp("v4_slot_pc", pc, 32'hBFC0_0004);
        run_instr(32'h1000_0010, 1'b1, 2'b00, 32'd0);
        cmp("v4_redirect_pc", pc, 32'hBFC0_0000);
        run_instr(32'h0000_0000, 1'b0, 2'b00, 32'd0);
        cmp("v4_after_pc", pc, 32'hBFC0_0004);

        // J index jump
        run_instr(32'h0800_0010, 1'b1, 2'b01, 32'd0);
        cmp("j_slot_pc", pc, 32'hBFC0_0008);
        run_instr(32'h0000_0000, 1'b0, 2'b00, 32'd0);
        cmp("j_target_pc", pc, 32'hB000_0040);

        // JR near top of address space; link wraps, then pc+4 wraps to 0
        do_reset();
        run_instr(32'h03E0_0008, 1'b1, 2'b11, 32'hFFFF_FFFC);
        run_instr(32'h0000_0000, 1'b0, 2'b00, 32'd0);
        cmp("wrap_pc", pc, 32'hFFFF_FFFC);
        cmp("wrap_link", link_addr, 32'h0000_0004);
        run_instr(32'h0000_0000, 1'b0, 2'b00, 32'd0);
        cmp("wrap_halt_state", {30'd0, state}, 32'd3);

        // JR to zero halts after delay slot; HALT is sticky
        do_reset();
        run_instr(32'h03E0_0008, 1'b1, 2'b10, 32'h0);
        cmp("v5_slot_pc", pc, 32'hBFC0_0004);
        run_instr(32'hAAAA_5555, 1'b0, 2'b00, 32'd0);
        cmp("v5_halt_state", {30'd0, state}, 32'd3);
        cmp("v5_halt_pc", pc, 32'h0);
        cmp("v5_halt_active", {31'd0, active}, 32'd0);
        for (int i = 0; i < 10; i++) begin
            step(1'b0, 1'b0, 32'h1111_0000 + 32'(i), 1'b1, 1'b1, 2'b10, 32'h40);
            cmp("v5_sticky_state", {30'd0, state}, 32'd3);
            cmp("v5_sticky_instr", instr, 32'hAAAA_5555);
        end

        // Reset in EXEC1 while stalled, with a redirect pending
        do_reset();
        run_instr(32'h1000_0004, 1'b1, 2'b00, 32'd0);
        step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 2'b00, 32'd0);
        step(1'b1, 1'b1, 32'h0, 1'b0, 1'b0, 2'b00, 32'd0);
        cmp("v6_state", {30'd0, state}, 32'd0);
        cmp("v6_pc", pc, 32'hBFC0_0000);
        run_instr(32'h0000_0000, 1'b0, 2'b00, 32'd0);
        cmp("v6_no_pending", pc, 32'hBFC0_0004);

        // Reset during EXEC2
        step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 2'b00, 32'd0);
        step(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 2'b00, 32'd0);
        do_reset();
        cmp("rst_exec2_state", {30'd0, state}, 32'd0);
        cmp("rst_exec2_pc", pc, 32'hBFC0_0000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
